// File: rtl/branch_redirect_ctrl_pkg.sv
// branch_redirect_ctrl_pkg: funct3 branch codes, FSM state encodings and PC increment.
package branch_redirect_ctrl_pkg;
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_REDIRECT = 2'b01;
    localparam logic [1:0] ST_FLUSH    = 2'b10;

    localparam int PC_INC = 4;
endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// branch_redirect_ctrl_if: redirect handshake and pipeline-control channel toward fetch.
interface branch_redirect_ctrl_if #(parameter int XLEN = 32);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_ready;
    logic            flush_if;
    logic            flush_id;
    logic            stall;

    modport master(output redirect_valid, redirect_pc, flush_if, flush_id, stall, input fetch_ready);
    modport slave(input redirect_valid, redirect_pc, flush_if, flush_id, stall, output fetch_ready);
endinterface

// File: rtl/branch_redirect_ctrl_cond.sv
// branch_cond_eval: funct3 plus ALU flags of A-B to branch-taken decision.
module branch_cond_eval
    import branch_redirect_ctrl_pkg::*;
(
    input  logic [2:0] f3,
    input  logic       zf,
    input  logic       sf,
    input  logic       vf,
    input  logic       cf,
    output logic       taken
);
    always_comb begin
        taken = 1'b0;
        case (f3)
            BR_BEQ:  taken = zf;
            BR_BNE:  taken = !zf;
            BR_BLT:  taken = sf ^ vf;
            BR_BGE:  taken = !(sf ^ vf);
            BR_BLTU: taken = !cf;
            BR_BGEU: taken = cf;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: EX-stage branch/jump resolver driving fetch redirect and IF/ID flush.
// Optional BRANCH_PREDICT_EN compares ex_pred_taken against the resolved outcome.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_f3,
    input  logic            alu_zf,
    input  logic            alu_sf,
    input  logic            alu_vf,
    input  logic            alu_cf,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    branch_redirect_ctrl_if.master fe,
    output logic            resolved_taken
);
    logic [1:0]      state;
    logic [3:0]      cnt;
    logic [XLEN-1:0] rpc;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] fall;
    logic            cond;
    logic            taken;
    logic            pred;
    logic            fire;
    logic            mis;

    branch_cond_eval u_cond (
        .f3   (ex_f3),
        .zf   (alu_zf),
        .sf   (alu_sf),
        .vf   (alu_vf),
        .cf   (alu_cf),
        .taken(cond)
    );

`ifdef BRANCH_PREDICT_EN
    assign pred = ex_pred_taken;
`else
    logic unused_pred;
    assign unused_pred = ex_pred_taken;
    assign pred        = 1'b0;
`endif

    always_comb begin
        taken = ex_is_jalr | ex_is_jal | (ex_is_branch & cond);
        tgt   = ex_is_jalr ? {ex_target[XLEN-1:1], 1'b0} : ex_target;
        fall  = ex_pc + XLEN'(PC_INC);
        fire  = (state == ST_IDLE) & ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr);
        mis   = fire & (taken ^ pred);
    end

    // Any unused encoding falls back to IDLE; REDIRECT only leaves on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            rpc            <= '0;
            resolved_taken <= 1'b0;
        end else begin
            resolved_taken <= fire & taken;
            if (mis) begin
                rpc   <= taken ? tgt : fall;
                state <= ST_REDIRECT;
            end else if (state == ST_REDIRECT && fe.fetch_ready) begin
                cnt   <= 4'(FLUSH_CYCLES);
                state <= ST_FLUSH;
            end else if (state == ST_FLUSH) begin
                cnt   <= cnt - 4'd1;
                state <= (cnt == 4'd1) ? ST_IDLE : ST_FLUSH;
            end else if (state != ST_REDIRECT) begin
                state <= ST_IDLE;
            end
        end
    end

    assign fe.redirect_valid = (state == ST_REDIRECT);
    assign fe.redirect_pc    = rpc;
    assign fe.flush_if       = (state == ST_FLUSH);
    assign fe.flush_id       = (state == ST_FLUSH);
    assign fe.stall          = (state != ST_IDLE);
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: vector table, reset-abort sequence and operand-level random check.
module tb_branch_redirect_ctrl;
    localparam int FC = 2;

    typedef struct {
        logic        v, br, jal, jalr;
        logic [2:0]  f3;
        logic [3:0]  fl;
        logic [31:0] pc, tgt;
        logic        pred;
        int          delay;
        logic        e_taken, e_mis;
        logic [31:0] e_pc;
    } vec_t;

    logic        clk = 0, rst_n = 0;
    logic        ex_valid = 0, ex_is_branch = 0, ex_is_jal = 0, ex_is_jalr = 0;
    logic [2:0]  ex_f3 = 0;
    logic        alu_zf = 0, alu_sf = 0, alu_vf = 0, alu_cf = 0;
    logic [31:0] ex_pc = 0, ex_target = 0;
    logic        ex_pred_taken = 0;
    logic        resolved_taken;
    int          n_cmp = 0, n_bad = 0;
    vec_t        tbl[$];

    branch_redirect_ctrl_if #(.XLEN(32)) bus ();

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_f3(ex_f3),
        .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_vf(alu_vf), .alu_cf(alu_cf),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .fe(bus), .resolved_taken(resolved_taken)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, br, jal, jalr, input logic [2:0] f3,
                                input logic [3:0] fl, input logic [31:0] pc, tgt,
                                input logic pred, input int delay, input logic et, em,
                                input logic [31:0] ep);
        vec_t r;
        r.v = v; r.br = br; r.jal = jal; r.jalr = jalr; r.f3 = f3; r.fl = fl;
        r.pc = pc; r.tgt = tgt; r.pred = pred; r.delay = delay;
        r.e_taken = et; r.e_mis = em; r.e_pc = ep;
        return r;
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        bus.fetch_ready = 0;
    endtask

    task automatic junk_inputs();
        ex_valid = 1; ex_is_jalr = 1; ex_is_branch = 1;
        ex_target = $urandom; ex_pc = $urandom;
    endtask

    // Called right after a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run(input vec_t t, input string nm);
        ex_valid = t.v; ex_is_branch = t.br; ex_is_jal = t.jal; ex_is_jalr = t.jalr;
        ex_f3 = t.f3; {alu_zf, alu_sf, alu_vf, alu_cf} = t.fl;
        ex_pc = t.pc; ex_target = t.tgt; ex_pred_taken = t.pred;
        bus.fetch_ready = 1'($urandom);
        @(negedge clk);
        chk({nm, " resolved_taken"}, 32'(resolved_taken), 32'(t.e_taken));
        chk({nm, " redirect_valid"}, 32'(bus.redirect_valid), 32'(t.e_mis));
        chk({nm, " stall"}, 32'(bus.stall), 32'(t.e_mis));
        if (t.e_mis) begin
            for (int i = 0; i <= t.delay; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    chk({nm, " pulse_once"}, 32'(resolved_taken), 0);
                    chk({nm, " rv_hold"}, 32'(bus.redirect_valid), 1);
                end
                chk({nm, " redirect_pc"}, bus.redirect_pc, t.e_pc);
                chk({nm, " flush_in_redirect"}, 32'(bus.flush_if), 0);
                junk_inputs();
                bus.fetch_ready = (i == t.delay);
            end
            for (int j = 0; j < FC; j++) begin
                @(negedge clk);
                chk({nm, " flush_if"}, 32'(bus.flush_if), 1);
                chk({nm, " flush_id"}, 32'(bus.flush_id), 1);
                chk({nm, " rv_in_flush"}, 32'(bus.redirect_valid), 0);
                chk({nm, " stall_in_flush"}, 32'(bus.stall), 1);
                bus.fetch_ready = 0;
            end
        end
        idle_inputs();
        @(negedge clk);
        chk({nm, " idle_stall"}, 32'(bus.stall), 0);
        chk({nm, " idle_rv"}, 32'(bus.redirect_valid), 0);
        chk({nm, " idle_flush"}, 32'(bus.flush_if | bus.flush_id), 0);
        chk({nm, " idle_pulse"}, 32'(resolved_taken), 0);
    endtask

    // Reference: derive flags and outcome from actual operands A and B.
    function automatic vec_t model(input logic v, br, jal, jalr, input logic [2:0] f3,
                                   input logic [31:0] a, b, pc, tgt, input logic pred,
                                   input int delay);
        logic [32:0] d;
        logic        c, tk, pe, fire;
        logic [3:0]  fl;
        d  = {1'b0, a} - {1'b0, b};
        fl = {a == b, d[31], (a[31] != b[31]) && (d[31] != a[31]), a >= b};
        case (f3)
            3'd0: c = (a == b);
            3'd1: c = (a != b);
            3'd4: c = ($signed(a) < $signed(b));
            3'd5: c = ($signed(a) >= $signed(b));
            3'd6: c = (a < b);
            3'd7: c = (a >= b);
            default: c = 0;
        endcase
`ifdef BRANCH_PREDICT_EN
        pe = pred;
`else
        pe = 0;
`endif
        fire = v && (br || jal || jalr);
        tk   = fire && (jal || jalr || (br && c));
        return mk(v, br, jal, jalr, f3, fl, pc, tgt, pred, delay, tk, fire && (tk != pe),
                  !tk ? pc + 32'd4 : jalr ? tgt & ~32'd1 : tgt);
    endfunction

    initial begin
        idle_inputs();
        tbl.push_back(mk(1,1,0,0, 3'b000, 4'b1000, 32'h100, 32'h140, 0, 0, 1, 1, 32'h140));
        tbl.push_back(mk(1,1,0,0, 3'b110, 4'b0001, 32'h200, 32'h240, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0, 3'b010, 4'b1111, 32'h204, 32'h260, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0, 3'b011, 4'b0000, 32'h208, 32'h260, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,0,0,1, 3'b000, 4'b0000, 32'h1000, 32'h2003, 0, 4, 1, 1, 32'h2002));
        tbl.push_back(mk(1,1,0,0, 3'b001, 4'b1000, 32'h300, 32'h280, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0, 3'b100, 4'b0100, 32'h400, 32'h480, 0, 1, 1, 1, 32'h480));
        tbl.push_back(mk(1,1,0,0, 3'b101, 4'b0100, 32'h404, 32'h480, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0, 3'b111, 4'b0000, 32'h408, 32'h480, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0, 3'b110, 4'b0000, 32'h40C, 32'h500, 0, 2, 1, 1, 32'h500));
        tbl.push_back(mk(1,1,1,0, 3'b000, 4'b0000, 32'h600, 32'h1001, 0, 0, 1, 1, 32'h1001));
        tbl.push_back(mk(1,1,1,1, 3'b000, 4'b0000, 32'h604, 32'h1001, 0, 0, 1, 1, 32'h1000));
        tbl.push_back(mk(0,0,1,0, 3'b000, 4'b0000, 32'h608, 32'h700, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 3'b000, 4'b1000, 32'h60C, 32'h700, 0, 0, 0, 0, 0));
`ifdef BRANCH_PREDICT_EN
        tbl.push_back(mk(1,1,0,0, 3'b101, 4'b0110, 32'h800, 32'h900, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1,1,0,0, 3'b100, 4'b0000, 32'h804, 32'h900, 1, 0, 0, 1, 32'h808));
        tbl.push_back(mk(1,1,0,0, 3'b100, 4'b0000, 32'hFFFFFFFC, 32'h900, 1, 1, 0, 1, 32'h0));
        tbl.push_back(mk(1,0,1,0, 3'b000, 4'b0000, 32'h810, 32'hA00, 1, 0, 1, 0, 0));
`else
        tbl.push_back(mk(1,1,0,0, 3'b101, 4'b0110, 32'h800, 32'h900, 1, 0, 1, 1, 32'h900));
        tbl.push_back(mk(1,1,0,0, 3'b100, 4'b0000, 32'hFFFFFFFC, 32'h900, 1, 0, 0, 0, 0));
`endif
        #1;
        chk("reset rv", 32'(bus.redirect_valid), 0);
        chk("reset pc", bus.redirect_pc, 0);
        chk("reset stall", 32'(bus.stall), 0);
        chk("reset flush", 32'(bus.flush_if | bus.flush_id), 0);
        chk("reset pulse", 32'(resolved_taken), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        foreach (tbl[k]) run(tbl[k], $sformatf("vec%0d", k));

        // Reset dropped in the first FLUSH cycle aborts everything asynchronously.
        ex_valid = 1; ex_is_branch = 1; ex_f3 = 3'b000; {alu_zf, alu_sf, alu_vf, alu_cf} = 4'b1000;
        ex_pc = 32'h100; ex_target = 32'h140; ex_pred_taken = 0; bus.fetch_ready = 1;
        @(negedge clk);
        chk("rst_seq redirect", 32'(bus.redirect_valid), 1);
        idle_inputs(); bus.fetch_ready = 1;
        @(negedge clk);
        chk("rst_seq in_flush", 32'(bus.flush_if), 1);
        #2 rst_n = 0;
        #1;
        chk("rst_async flush_if", 32'(bus.flush_if), 0);
        chk("rst_async flush_id", 32'(bus.flush_id), 0);
        chk("rst_async stall", 32'(bus.stall), 0);
        chk("rst_async rv", 32'(bus.redirect_valid), 0);
        chk("rst_async pc", bus.redirect_pc, 0);
        @(negedge clk);
        chk("rst_held stall", 32'(bus.stall), 0);
        rst_n = 1;
        bus.fetch_ready = 0;
        @(negedge clk);
        run(mk(1,1,0,0, 3'b001, 4'b0000, 32'h300, 32'h280, 0, 1, 1, 1, 32'h280), "post_rst_bne");

        for (int n = 0; n < 300; n++) begin
            logic [2:0]  kind;
            logic [31:0] a, b, pc;
            kind = 3'($urandom_range(0, 7));
            a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : {$urandom, 2'b00} >> 2 << 2;
            run(model(kind != 3'd7, kind[0] | (kind == 3'd6), kind[1], kind == 3'd4 || kind == 3'd5,
                      3'($urandom), a, b, pc, $urandom, 1'($urandom), $urandom_range(0, 3)),
                $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Execute-stage control-flow resolver for the RISC-V core.
- Evaluates the branch condition from ALU flags and funct3, and resolves JAL/JALR.
- On a misprediction it drives a PC redirect to fetch with a valid/ready handshake, then sequences a fixed-length flush of IF/ID.
- Sits between the ALU/EX stage and the PC/fetch unit. Holds a pipeline stall while a redirect is in flight.

Parameters:
- XLEN, 32, data/address width.
- FLUSH_CYCLES, 2, cycles flush_if/flush_id stay asserted after redirect acceptance; legal range 1..15.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction this cycle.
- ex_is_branch  in  1  conditional branch.
- ex_is_jal  in  1  JAL.
- ex_is_jalr  in  1  JALR.
- ex_f3  in  3  funct3 of the branch.
- alu_zf  in  1  A-B == 0.
- alu_sf  in  1  sign of A-B.
- alu_vf  in  1  signed overflow of A-B.
- alu_cf  in  1  carry-out of A-B; 1 means A >= B unsigned.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_target  in  XLEN  computed target (PC+imm, or rs1+imm for JALR).
- ex_pred_taken  in  1  fetch-time prediction; used only with the optional feature.
- fetch_ready  in  1  fetch accepts the redirect.
- redirect_valid  out  1  redirect request pending.
- redirect_pc  out  XLEN  new fetch PC.
- flush_if  out  1  kill the IF stage.
- flush_id  out  1  kill the ID stage.
- stall  out  1  freeze PC/IF/ID/EX advance.
- resolved_taken  out  1  one-cycle pulse: a control-flow instruction resolved taken.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; redirect_pc 0; flush counter 0. Reset asserted mid-REDIRECT or mid-FLUSH aborts immediately; no partial redirect survives.
- Condition evaluation (combinational):
  - BEQ(000): zf. BNE(001): !zf.
  - BLT(100): sf^vf. BGE(101): !(sf^vf).
  - BLTU(110): !cf. BGEU(111): cf.
  - 010/011: not taken.
- Priority if more than one type flag is set: jalr > jal > branch. JAL/JALR are always taken.
- JALR target: ex_target with bit 0 cleared.
- Fall-through PC = ex_pc+4, mod 2^XLEN (wraps silently).
- States:
  - IDLE: stall=0. A resolution fires when ex_valid and any type flag is set. resolved_taken is pulsed the next cycle if taken. mispredict = taken XOR pred; pred is 0 without the feature. On mispredict: latch redirect_pc (taken ? target : pc+4), go to REDIRECT. Otherwise stay in IDLE.
  - REDIRECT: redirect_valid=1, stall=1. redirect_pc is held stable until the handshake. When fetch_ready=1 in a cycle, the handshake completes: load the counter with FLUSH_CYCLES, go to FLUSH. Back-to-back redirects cannot occur. fetch_ready high on entry completes in one cycle.
  - FLUSH: flush_if=flush_id=1, stall=1, redirect_valid=0. The counter decrements each cycle. At count 1 the next state is IDLE, so flush lasts exactly FLUSH_CYCLES cycles.
- Latency: resolution edge → redirect_valid high at the next cycle; minimum mispredict penalty is 1+FLUSH_CYCLES cycles after the handshake cycle.
- ex_valid and type flags are ignored outside IDLE; upstream is stalled.

Optional Feature:
- BRANCH_PREDICT_EN defined:
  - ex_pred_taken is compared with the actual outcome.
  - A correctly predicted taken instruction resolves with no redirect.
  - Predicted taken but actually not taken redirects to pc+4.
- Undefined: ex_pred_taken is ignored (port retained); every taken branch or jump redirects and every not-taken branch does not.

Decomposition:
- Shared defines file: BR_BEQ..BR_BGEU funct3 codes, FSM state encodings (IDLE/REDIRECT/FLUSH, 2 bits), and the fixed PC increment of 4.
- One natural combinational sub-module: branch_cond_eval (f3 + flags → taken).

Test Plan:
- BEQ, zf=1, pc=0x100, target=0x140, fetch_ready=1 → redirect_valid 1 cycle with redirect_pc=0x140, then flush_if/flush_id 2 cycles, stall 3 cycles, resolved_taken pulse.
- BLTU with cf=1, and f3=010 with any flags → no redirect, stall stays 0.
- JALR target=0x2003 with fetch_ready held low 4 cycles → redirect_pc=0x2002 stable, redirect_valid high all 4 cycles plus the accept cycle; a new ex_valid during this window is ignored.
- rst_n dropped during FLUSH → all outputs 0 immediately (async); after release, a new BNE with zf=0 resolves normally.
- With BRANCH_PREDICT_EN: BGE sf=vf=1 with pred=1 → no redirect. BLT sf=vf=0 with pred=1 → redirect_pc=pc+4. pc=0xFFFFFFFC → redirect_pc=0x00000000.
